// File: rtl/add_round_key_stream_pkg.sv
// rtl/add_round_key_stream_pkg.sv - shared AES datapath types and round-count lookup
package add_round_key_stream_pkg;

  typedef logic [127:0] state_t;
  typedef logic [127:0] round_key_t;

  typedef enum logic [1:0] {
    KEY_SIZE_128,
    KEY_SIZE_192,
    KEY_SIZE_256
  } key_size_t;

  typedef struct packed {
    state_t state;
    logic   err;
  } ark_result_t;

  // 128/192/256-bit cipher keys give 10/12/14 rounds
  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

endpackage

// File: rtl/add_round_key_stream_fifo.sv
// rtl/add_round_key_stream_fifo.sv - ark_fifo: synchronous FIFO holding AddRoundKey results
module ark_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CW'(DEPTH));
  assign do_pop   = pop & rd_valid;
  // Empty FIFO presents zero rather than stale storage
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = next_ptr(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(do_pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/add_round_key_stream.sv
// rtl/add_round_key_stream.sv - streaming AddRoundKey stage with writable round-key bank
module add_round_key_stream
  import add_round_key_stream_pkg::*;
#(
  parameter int KEY_BITS   = 128,
  parameter int FIFO_DEPTH = 2,
  localparam int NR        = nr_of(KEY_BITS)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          key_wr_en,
  input  logic [3:0]    key_wr_idx,
  input  logic [127:0]  key_wr_data,
  input  logic          key_clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_state,
  input  logic [3:0]    in_round,
  input  logic          in_decrypt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_state,
  output logic          out_err,
  output logic [NR:0]   key_loaded
);

  round_key_t  key_bank_q [NR+1];
  round_key_t  key_bank_d [NR+1];
  logic [NR:0] key_loaded_q, key_loaded_d;

  logic        fifo_full;
  logic        push;
  logic        round_ok;
  logic        key_hit;
  logic [3:0]  key_idx;
  logic [3:0]  sel_idx;
  ark_result_t result;
  ark_result_t head;

  assign in_ready   = !fifo_full | out_ready;
  assign push       = in_valid & in_ready;
  assign key_loaded = key_loaded_q;

  always_comb begin
    round_ok     = (in_round <= 4'(NR));
    key_idx      = in_decrypt ? (4'(NR) - in_round) : in_round;
    // Out-of-range rounds never index the bank; they are flagged as errors
    sel_idx      = round_ok ? key_idx : '0;
    key_hit      = round_ok && key_loaded_q[sel_idx];
    result.err   = !key_hit;
    result.state = key_hit ? (in_state ^ key_bank_q[sel_idx]) : in_state;
  end

  always_comb begin
    key_bank_d   = key_bank_q;
    key_loaded_d = key_loaded_q;
    if (key_clear) begin
      key_loaded_d = '0;
    end else if (key_wr_en && (key_wr_idx <= 4'(NR))) begin
      key_bank_d[key_wr_idx]   = key_wr_data;
      key_loaded_d[key_wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= NR; i++) key_bank_q[i] <= '0;
      key_loaded_q <= '0;
    end else begin
      key_bank_q   <= key_bank_d;
      key_loaded_q <= key_loaded_d;
    end
  end

  ark_fifo #(
    .WIDTH ($bits(ark_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (result),
    .pop       (out_ready),
    .rd_data   (head),
    .rd_valid  (out_valid),
    .full      (fifo_full)
  );

  assign out_state = head.state;
  assign out_err   = head.err;

endmodule

// File: tb/tb_add_round_key_stream.sv
// tb/tb_add_round_key_stream.sv - directed self-checking bench for add_round_key_stream
module tb_add_round_key_stream;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] K2   = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
  localparam logic [127:0] K3   = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
  localparam logic [127:0] K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ST   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] E_K0 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] E_K10= 128'h13003f4ca7c12c607b9e0d3081f6de3a;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic          clock = 1'b0;
  logic          reset_n;
  logic          key_wr_en;
  logic [3:0]    key_wr_idx;
  logic [127:0]  key_wr_data;
  logic          key_clear;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_state;
  logic [3:0]    in_round;
  logic          in_decrypt;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_state;
  logic          out_err;
  logic [10:0]   key_loaded;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  add_round_key_stream #(.KEY_BITS(128), .FIFO_DEPTH(2)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .key_clear   (key_clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_round    (in_round),
    .in_decrypt  (in_decrypt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .out_err     (out_err),
    .key_loaded  (key_loaded)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] data);
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    tick();
    key_wr_en   = 1'b0;
  endtask

  // One block through an empty FIFO with out_ready=1: visible one cycle after accept, gone the next
  task automatic xfer1(input string tag, input logic [127:0] st, input logic [3:0] rnd,
                       input logic dec, input logic [127:0] exp_state, input logic exp_err);
    in_state   = st;
    in_round   = rnd;
    in_decrypt = dec;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_state"}, out_state, exp_state);
    chk({tag, "_err"},   128'(out_err), 128'(exp_err));
    tick();
    chk({tag, "_drained"}, 128'(out_valid), 128'(1'b0));
  endtask

  initial begin
    reset_n     = 1'b0;
    key_wr_en   = 1'b0;
    key_wr_idx  = '0;
    key_wr_data = '0;
    key_clear   = 1'b0;
    in_valid    = 1'b0;
    in_state    = '0;
    in_round    = '0;
    in_decrypt  = 1'b0;
    out_ready   = 1'b1;
    #1;
    chk("rst_out_valid",  128'(out_valid), 128'(1'b0));
    chk("rst_out_err",    128'(out_err), 128'(1'b0));
    chk("rst_out_state",  out_state, 128'h0);
    chk("rst_key_loaded", 128'(key_loaded), 128'h0);
    tick();
    tick();
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));

    // FIPS-197 C.1 round 0
    wr_key(4'd0, K0);
    xfer1("enc_r0", ST, 4'd0, 1'b0, E_K0, 1'b0);

    // Full key schedule; decrypt round 0 selects key 10, decrypt round 10 selects key 0
    wr_key(4'd1, K1);
    wr_key(4'd2, K2);
    wr_key(4'd3, K3);
    for (int i = 4; i <= 9; i++) begin
      logic [7:0] b;
      b = 8'(i);
      wr_key(4'(i), {16{b}});
    end
    wr_key(4'd10, K10);
    chk("all_loaded", 128'(key_loaded), 128'h7ff);
    xfer1("dec_r0",  ST, 4'd0,  1'b1, E_K10, 1'b0);
    xfer1("dec_r10", ST, 4'd10, 1'b1, E_K0,  1'b0);

    // Backpressure: zero state makes each output equal to its round key
    out_ready  = 1'b0;
    in_state   = '0;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    in_round   = 4'd0;
    #1;
    chk("bp_ready0", 128'(in_ready), 128'(1'b1));
    tick();
    in_round = 4'd1;
    #1;
    chk("bp_ready1", 128'(in_ready), 128'(1'b1));
    tick();
    in_round = 4'd2;
    #1;
    chk("bp_ready_full", 128'(in_ready), 128'(1'b0));
    tick();
    chk("bp_head_stable", out_state, K1 ^ K1 ^ K0);
    chk("bp_still_full", 128'(in_ready), 128'(1'b0));
    out_ready = 1'b1;
    #1;
    chk("bp_comb_ready", 128'(in_ready), 128'(1'b1));
    tick();
    in_valid = 1'b0;
    chk("bp_second", out_state, K1);
    tick();
    chk("bp_third", out_state, K2);
    chk("bp_third_valid", 128'(out_valid), 128'(1'b1));
    tick();
    chk("bp_empty", 128'(out_valid), 128'(1'b0));

    // Errors: round beyond NR, then an unwritten key after a clear
    xfer1("err_r11", ST, 4'd11, 1'b0, ST, 1'b1);
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    chk("clear_loaded", 128'(key_loaded), 128'h0);
    wr_key(4'd0, K0);
    xfer1("err_nokey3", ST, 4'd3, 1'b0, ST, 1'b1);
    xfer1("after_err",  ST, 4'd0, 1'b0, E_K0, 1'b0);

    // Same-cycle key write and accept uses the old key
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd0;
    key_wr_data = ONES;
    in_state    = '0;
    in_round    = 4'd0;
    in_valid    = 1'b1;
    tick();
    key_wr_en = 1'b0;
    in_valid  = 1'b0;
    chk("wr_same_old", out_state, K0);
    tick();
    xfer1("wr_next_new", 128'h0, 4'd0, 1'b0, ONES, 1'b0);
    wr_key(4'd15, K3);
    chk("wr_idx_oob", 128'(key_loaded), 128'h001);
    key_clear   = 1'b1;
    key_wr_en   = 1'b1;
    key_wr_idx  = 4'd1;
    key_wr_data = K1;
    tick();
    key_clear = 1'b0;
    key_wr_en = 1'b0;
    chk("clear_prio", 128'(key_loaded), 128'h0);

    // Asynchronous reset with two entries queued
    wr_key(4'd0, K0);
    out_ready = 1'b0;
    in_state  = ST;
    in_round  = 4'd0;
    in_valid  = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("q2_valid", 128'(out_valid), 128'(1'b1));
    chk("q2_full",  128'(in_ready), 128'(1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid",  128'(out_valid), 128'(1'b0));
    chk("arst_state",  out_state, 128'h0);
    chk("arst_loaded", 128'(key_loaded), 128'h0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    chk("arst_no_output", 128'(out_valid), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
